usb_fs_tx_serializer: RTL and testbench

- Full-speed USB transmit line encoder. Sits directly upstream of the USB pin interface and drives its data-output pins: D+ output, D- output and the shared output-enable used for both D+ and D- enables.
- Accepts packet bytes over a valid/ready stream. Emits SYNC, then the LSB-first NRZI-encoded bit-stuffed payload, then EOP, at 12 Mbit/s derived from the core clock.

---
 rtl/usb_fs_tx_serializer_if.sv | 15 +
 rtl/usb_fs_tx_serializer.sv | 171 +++++++++++++++++
 tb/tb_usb_fs_tx_serializer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_tx_serializer_if.sv
// usb_fs_tx_serializer_if: byte stream handshake feeding the USB FS transmit serializer.
// Rev 1.0
`default_nettype none

interface usb_fs_tx_serializer_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_ready_o;

  modport master (output tx_valid_i, output tx_data_i, output tx_last_i, input tx_ready_o);
  modport slave  (input tx_valid_i, input tx_data_i, input tx_last_i, output tx_ready_o);
endinterface

`default_nettype wire

// File: rtl/usb_fs_tx_serializer.sv
// usb_fs_tx_serializer: full-speed USB line encoder (SYNC, NRZI + bit stuffing, EOP, gap).
// Rev 1.0
`default_nettype none

module usb_fs_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int IPG_BITS     = 2
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  usb_fs_tx_serializer_if.slave     tx,
  output logic                      usb_dp_o,
  output logic                      usb_dn_o,
  output logic                      usb_oe_o,
  output logic                      tx_busy_o,
  output logic                      underrun_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (IPG_BITS > 1) ? $clog2(IPG_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(IPG_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
    S_EOP  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      byte_q;
  logic            last_q;
  logic [2:0]      ones;
  logic            lvl;

  logic            strobe;
  logic            pre_strobe;
  logic            stuff;
  logic            byte_end;
  logic            need_byte;
  logic            end_pkt;
  logic            tx_bit;
  logic            next_lvl;
  logic [2:0]      next_ones;

  // idx/ones only change on a strobe, so the handshake decision can be
  // made one cycle early and the ready pulse lands exactly on the strobe.
  always_comb begin
    strobe     = (state != S_IDLE) && (cnt == CNT_LAST);
    pre_strobe = (state != S_IDLE) && (cnt == CNT_PRE);
    stuff      = (state == S_DATA) && (ones == 3'd6);
    byte_end   = (idx == 3'd7) && !stuff;
    need_byte  = byte_end && ((state == S_SYNC) || ((state == S_DATA) && !last_q));
    end_pkt    = byte_end && (((state == S_DATA) && last_q) || !tx.tx_valid_i);

    tx_bit = 1'b1;
    if (stuff)                tx_bit = 1'b0;
    else if (idx == 3'd7)     tx_bit = tx.tx_data_i[0];
    else if (state == S_SYNC) tx_bit = (idx == 3'd6);
    else                      tx_bit = byte_q[idx + 3'd1];

    next_lvl  = tx_bit ? lvl : ~lvl;
    next_ones = tx_bit ? (ones + 3'd1) : 3'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      gap_cnt       <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      ones          <= '0;
      lvl           <= 1'b1;
      usb_dp_o      <= 1'b1;
      usb_dn_o      <= 1'b0;
      usb_oe_o      <= 1'b0;
      tx.tx_ready_o <= 1'b0;
      tx_busy_o     <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      tx.tx_ready_o <= pre_strobe && need_byte;
      underrun_o    <= 1'b0;

      if ((state == S_IDLE) || strobe) cnt <= '0;
      else                             cnt <= cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (tx.tx_valid_i) begin
            // First SYNC bit is a 0, so the line moves straight from J to K.
            state     <= S_SYNC;
            usb_oe_o  <= 1'b1;
            tx_busy_o <= 1'b1;
            idx       <= '0;
            ones      <= '0;
            lvl       <= 1'b0;
            usb_dp_o  <= 1'b0;
            usb_dn_o  <= 1'b1;
          end
        end

        S_SYNC, S_DATA: begin
          if (strobe) begin
            if (end_pkt) begin
              state      <= S_EOP;
              idx        <= '0;
              usb_dp_o   <= 1'b0;
              usb_dn_o   <= 1'b0;
              underrun_o <= need_byte;
            end else begin
              lvl      <= next_lvl;
              usb_dp_o <= next_lvl;
              usb_dn_o <= ~next_lvl;
              ones     <= next_ones;
              if (byte_end) begin
                byte_q <= tx.tx_data_i;
                last_q <= tx.tx_last_i;
                idx    <= '0;
                state  <= S_DATA;
              end else if (!stuff) begin
                idx <= idx + 3'd1;
              end
            end
          end
        end

        S_EOP: begin
          if (strobe) begin
            if (idx == 3'd2) begin
              state    <= S_GAP;
              usb_oe_o <= 1'b0;
              gap_cnt  <= '0;
              lvl      <= 1'b1;
              ones     <= '0;
            end else begin
              idx <= idx + 3'd1;
              if (idx == 3'd1) begin
                usb_dp_o <= 1'b1;
                usb_dn_o <= 1'b0;
              end
            end
          end
        end

        S_GAP: begin
          if (strobe) begin
            if (gap_cnt == GAP_LAST) begin
              state     <= S_IDLE;
              tx_busy_o <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_fs_tx_serializer.sv
// tb_usb_fs_tx_serializer: randomized packets scored against a bit-level line model.
// Rev 1.0
`default_nettype none

module tb_usb_fs_tx_serializer;

  localparam int CPB = 4;
  localparam int IPG = 2;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  usb_fs_tx_serializer_if tx ();
  logic dp, dn, oe, busy, und;

  usb_fs_tx_serializer #(.CLKS_PER_BIT(CPB), .IPG_BITS(IPG)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .tx         (tx),
    .usb_dp_o   (dp),
    .usb_dn_o   (dn),
    .usb_oe_o   (oe),
    .tx_busy_o  (busy),
    .underrun_o (und)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_sym[$];
  int exp_len[$];
  int exp_rdy[$];
  int exp_rcnt[$];
  int exp_und[$];
  logic [7:0] pkt[0:7];
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build the raw bit stream (SYNC + sent bytes), insert a 0 after
  // every six consecutive 1s, NRZI-encode from J, then append SE0 SE0 J.
  task automatic model(input int nsent, input bit under);
    int sym = 0;
    bit lv = 1'b1;
    int run = 0;
    int rc = 0;
    int last_rdy = -1;
    for (int g = 0; g <= nsent; g++) begin
      logic [7:0] v;
      v = (g == 0) ? 8'h80 : pkt[g-1];
      for (int i = 0; i < 8; i++) begin
        if (!v[i]) lv = ~lv;
        run = v[i] ? run + 1 : 0;
        exp_sym.push_back(lv ? LJ : LK);
        sym++;
        if (run == 6) begin
          lv = ~lv;
          run = 0;
          exp_sym.push_back(lv ? LJ : LK);
          sym++;
        end
      end
      if ((g < nsent) || under) begin
        exp_rdy.push_back(sym - 1);
        rc++;
        last_rdy = sym - 1;
      end
    end
    exp_sym.push_back(SE0);
    exp_sym.push_back(SE0);
    exp_sym.push_back(LJ);
    sym += 3;
    exp_len.push_back(sym);
    exp_rcnt.push_back(rc);
    exp_und.push_back(under ? last_rdy + 1 : -1);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx.tx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    tx.tx_valid_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_in_time", done, 1);
  endtask

  // Valid is left high after the final accept so packets run back to back.
  task automatic send(input int n, input int under_at);
    bit ok;
    bit seen;
    model((under_at < 0) ? n : under_at, under_at >= 0);
    if (under_at == 0) begin
      wait_idle();
      tx.tx_data_i = pkt[0];
      tx.tx_last_i = (n == 1);
      tx.tx_valid_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (oe) begin
          seen = 1'b1;
          break;
        end
      end
      check("sync_start_in_time", seen, 1);
      @(posedge clk);
      #1;
      wait_idle();
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i == under_at) begin
        wait_idle();
        return;
      end
      tx.tx_data_i = pkt[i];
      tx.tx_last_i = (i == n - 1);
      tx.tx_valid_i = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        wait_idle();
        return;
      end
    end
  endtask

  // Monitor: decodes the pins every cycle and pops the scoreboard.
  int c = 0, rcnt = 0, useen = -1, ucnt = 0, gcnt = 0, idle_cnt = 0;
  bit in_pkt = 1'b0, in_gap = 1'b0, seen_first = 1'b0;
  logic [1:0] cur = 2'b11;

  always @(negedge clk) begin
    if (!rst_ni) begin
      in_pkt = 1'b0;
      in_gap = 1'b0;
      seen_first = 1'b0;
      idle_cnt = 0;
    end else if (mon_en) begin
      if (oe) begin
        if (!in_pkt) begin
          if (seen_first) check("ipg_min", (idle_cnt >= IPG * CPB + 1), 1);
          in_pkt = 1'b1;
          in_gap = 1'b0;
          c = 0; rcnt = 0; useen = -1; ucnt = 0;
        end
        if (c % CPB == 0) begin
          check("sym_queue_nonempty", exp_sym.size() > 0, 1);
          cur = (exp_sym.size() > 0) ? exp_sym.pop_front() : 2'b11;
        end
        check("line", {dp, dn}, cur);
        check("busy_in_pkt", busy, 1);
        if (tx.tx_ready_o) begin
          rcnt++;
          check("ready_phase", c % CPB, CPB - 1);
          check("ready_expected", exp_rdy.size() > 0, 1);
          if (exp_rdy.size() > 0) check("ready_bit", c / CPB, exp_rdy.pop_front());
        end
        if (und) begin
          ucnt++;
          useen = c / CPB;
          check("underrun_phase", c % CPB, 0);
        end
        c++;
      end else begin
        if (in_pkt) begin
          in_pkt = 1'b0;
          in_gap = 1'b1;
          gcnt = 0;
          idle_cnt = 0;
          seen_first = 1'b1;
          check("len_queue_nonempty", exp_len.size() > 0, 1);
          if (exp_len.size() > 0) begin
            check("oe_cycles", c, exp_len.pop_front() * CPB);
            check("ready_count", rcnt, exp_rcnt.pop_front());
            check("underrun_bit", useen, exp_und.pop_front());
            check("underrun_single", ucnt <= 1, 1);
          end
        end
        idle_cnt++;
        check("ready_low_when_oe_low", tx.tx_ready_o, 0);
        check("underrun_low_when_oe_low", und, 0);
        if (in_gap) begin
          if (busy) begin
            gcnt++;
            check("gap_line_j", {dp, dn}, LJ);
          end else begin
            check("gap_cycles", gcnt, IPG * CPB);
            in_gap = 1'b0;
          end
        end else begin
          check("idle_line_j", {dp, dn}, LJ);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n, ua;
    tx.tx_valid_i = 1'b0;
    tx.tx_data_i  = 8'h00;
    tx.tx_last_i  = 1'b0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dp", dp, 1);
    check("rst_dn", dn, 0);
    check("rst_oe", oe, 0);
    check("rst_ready", tx.tx_ready_o, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", und, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    pkt[0] = 8'h00; send(1, -1);
    pkt[0] = 8'hFF; send(1, -1);
    pkt[0] = 8'h3F; pkt[1] = 8'h00; send(2, -1);
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; send(3, 2);
    pkt[0] = 8'hA5; send(1, -1);
    pkt[0] = 8'hC3; pkt[1] = 8'h7E; send(2, -1);
    pkt[0] = 8'h9C; send(1, 0);

    for (int p = 0; p < 24; p++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0: pkt[i] = 8'h00;
          1: pkt[i] = 8'hFF;
          2: pkt[i] = 8'h3F;
          3: pkt[i] = 8'hFE;
          default: pkt[i] = 8'($urandom);
        endcase
      end
      ua = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send(n, ua);
    end

    // Mid-packet asynchronous reset during DATA bit 3.
    wait_idle();
    mon_en = 1'b0;
    tx.tx_data_i = 8'hA5;
    tx.tx_last_i = 1'b1;
    tx.tx_valid_i = 1'b1;
    wait_ready(ok);
    tx.tx_valid_i = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("pre_reset_oe", oe, 1);
    rst_ni = 1'b0;
    #1;
    check("midrst_dp", dp, 1);
    check("midrst_dn", dn, 0);
    check("midrst_oe", oe, 0);
    check("midrst_ready", tx.tx_ready_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_underrun", und, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    pkt[0] = 8'h5A; send(1, -1);

    wait_idle();
    repeat (4) @(negedge clk);
    check("sym_queue_drained", exp_sym.size(), 0);
    check("len_queue_drained", exp_len.size(), 0);
    check("ready_queue_drained", exp_rdy.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
